// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   latency      : n/a (types, constants and one constant function only)
//   backpressure : n/a
// Contents: stage indices into the stall vector, sequencer state encoding, stall masks.
package pipe_stall_ctrl_pkg;

  localparam int NUM_STG    = 5;
  // Bit positions in the stall vector; ID/EX sits at bit 2 between these.
  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

  // Flush counter only needs to reach FLUSH_CYCLES-1 (at most 3).
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    PCS_RUN   = 2'd0,
    PCS_MEMW  = 2'd1,
    PCS_FLUSH = 2'd2
  } pcs_state_e;

  // Mask that holds every stage from PC up to and including stage 'stg'.
  function automatic logic [NUM_STG-1:0] hold_through(input int stg);
    return NUM_STG'((32'd1 << (stg + 1)) - 32'd1);
  endfunction

  localparam logic [NUM_STG-1:0] STALL_IF  = hold_through(STG_PC);      // 00001
  localparam logic [NUM_STG-1:0] STALL_LU  = hold_through(STG_IF_ID);   // 00011
  localparam logic [NUM_STG-1:0] STALL_MEM = hold_through(STG_EX_MEM);  // 01111
  localparam logic [NUM_STG-1:0] STALL_ALL = hold_through(STG_MEM_WB);  // 11111

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Event/control bundle between the pipeline and the stall sequencer.
//   latency      : n/a (wires only)
//   backpressure : rdy_in low requests a full pipeline freeze
// Ports: master = pipeline side (drives events, consumes controls); slave = sequencer side.
interface pipe_stall_ctrl_if #(
  parameter int PERF_W = 32
);
  logic              rdy_in;
  logic              if_busy;
  logic              mem_busy;
  logic              id_load_use;
  logic              ex_branch_taken;
  logic [31:0]       ex_branch_target;
  logic [4:0]        stall;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              pc_redirect;
  logic [31:0]       pc_target;
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_flush_cnt;
  logic [PERF_W-1:0] perf_lu_cnt;

  modport master (
    output rdy_in, if_busy, mem_busy, id_load_use, ex_branch_taken, ex_branch_target,
    input  stall, flush_if_id, flush_id_ex, pc_redirect, pc_target,
    input  perf_stall_cnt, perf_flush_cnt, perf_lu_cnt
  );

  modport slave (
    input  rdy_in, if_busy, mem_busy, id_load_use, ex_branch_taken, ex_branch_target,
    output stall, flush_if_id, flush_id_ex, pc_redirect, pc_target,
    output perf_stall_cnt, perf_flush_cnt, perf_lu_cnt
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter: counts enable cycles, sticks at all-ones.
//   latency      : count visible one cycle after the enabled edge
//   backpressure : none; en is sampled every cycle
// Ports: clk_in, rst_in (sync, active-high), en, cnt[W-1:0].
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: arbitrates mem-busy, redirect, load-use, fetch-busy into stage controls.
//   latency      : controls are combinational from state + inputs (0 cycles); state/counters registered
//   backpressure : rdy_in low stalls all five stages and freezes state and counters
// Ports: clk_in, rst_in (sync, active-high), bus (pipe_stall_ctrl_if.slave).
// Build option: define PERF_CNT_EN to enable the three saturating perf counters; otherwise they read 0.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,   // cycles flush_if_id stays high after a redirect (1..4)
  parameter int PERF_W       = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  pipe_stall_ctrl_if.slave    bus
);

  localparam logic [CNT_W-1:0] FLUSH_RELOAD   = CNT_W'(FLUSH_CYCLES - 1);
  localparam pcs_state_e       AFTER_REDIRECT = (FLUSH_CYCLES > 1) ? PCS_FLUSH : PCS_RUN;

  pcs_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_STG-1:0] stall;
  logic               flush_if_id;
  logic               flush_id_ex;
  logic               pc_redirect;
  logic [31:0]        pc_target;
  logic               do_redirect;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= PCS_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    stall       = '0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    do_redirect = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (!bus.rdy_in) begin
      stall = STALL_ALL;
    end else begin
      case (state_q)
        PCS_FLUSH: begin
          if (bus.mem_busy) begin
            // Keep squashing the fetch slot while MEM holds; count pauses.
            stall       = STALL_MEM;
            flush_if_id = 1'b1;
          end else if (bus.ex_branch_taken) begin
            do_redirect = 1'b1;
          end else begin
            flush_if_id = 1'b1;
            cnt_d       = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = PCS_RUN;
            end
          end
        end
        default: begin
          // RUN and MEM_WAIT share this path: once memory releases, MEM_WAIT
          // resolves exactly like RUN so a branch parked in EX still redirects.
          if (bus.mem_busy) begin
            stall   = STALL_MEM;
            state_d = PCS_MEMW;
          end else if (bus.ex_branch_taken) begin
            do_redirect = 1'b1;
          end else begin
            state_d = PCS_RUN;
            if (bus.id_load_use) begin
              stall       = STALL_LU;
              flush_id_ex = 1'b1;
            end else if (bus.if_busy) begin
              stall       = STALL_IF;
              flush_if_id = 1'b1;
            end
          end
        end
      endcase

      if (do_redirect) begin
        pc_redirect = 1'b1;
        pc_target   = bus.ex_branch_target;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        state_d     = AFTER_REDIRECT;
        cnt_d       = FLUSH_RELOAD;
      end
    end
  end

  assign bus.stall       = stall;
  assign bus.flush_if_id = flush_if_id;
  assign bus.flush_id_ex = flush_id_ex;
  assign bus.pc_redirect = pc_redirect;
  assign bus.pc_target   = pc_target;

`ifdef PERF_CNT_EN
  logic stall_ev;
  logic lu_ev;

  // Controls are all zero while frozen except stall, hence the rdy_in gate here only.
  assign stall_ev = bus.rdy_in & (|stall);
  // flush_id_ex without a redirect is the load-use bubble.
  assign lu_ev    = flush_id_ex & ~pc_redirect;

  pipe_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk_in (clk_in), .rst_in (rst_in), .en (stall_ev),    .cnt (bus.perf_stall_cnt)
  );
  pipe_perf_cnt #(.W(PERF_W)) u_flush_cnt (
    .clk_in (clk_in), .rst_in (rst_in), .en (pc_redirect), .cnt (bus.perf_flush_cnt)
  );
  pipe_perf_cnt #(.W(PERF_W)) u_lu_cnt (
    .clk_in (clk_in), .rst_in (rst_in), .en (lu_ev),       .cnt (bus.perf_lu_cnt)
  );
`else
  assign bus.perf_stall_cnt = {PERF_W{1'b0}};
  assign bus.perf_flush_cnt = {PERF_W{1'b0}};
  assign bus.perf_lu_cnt    = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (FLUSH_CYCLES=3/PERF_W=32 and FLUSH_CYCLES=1/PERF_W=4)
// driven with identical stimulus and compared against a cycle-level behavioural model.
// Perf counter expectations follow PERF_CNT_EN as defined for this build.
module tb_pipe_stall_ctrl;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  pipe_stall_ctrl_if #(.PERF_W(32)) if_a ();
  pipe_stall_ctrl_if #(.PERF_W(4))  if_b ();

  pipe_stall_ctrl #(.FLUSH_CYCLES(3), .PERF_W(32)) u_dut_f3 (
    .clk_in (clk_in), .rst_in (rst_in), .bus (if_a.slave)
  );
  pipe_stall_ctrl #(.FLUSH_CYCLES(1), .PERF_W(4)) u_dut_f1 (
    .clk_in (clk_in), .rst_in (rst_in), .bus (if_b.slave)
  );

  int vectors    = 0;
  int miscompares = 0;

  // current stimulus
  bit          cur_rdy, cur_ifb, cur_mem, cur_lu, cur_br;
  logic [31:0] cur_tgt;

  // model: remaining flush cycles after the current one, and event tallies
  int              flush_left [2];
  longint unsigned pcnt [2][3];
  logic [39:0]     exp_ctl [2];
  bit              exp_red [2], exp_lub [2], exp_stalled [2];

  function automatic int fc_of(int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic longint unsigned max_of(int k);
    return (k == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction

  // Expected controls from the rules: frozen, inside a flush window, or normal issue.
  function automatic void model_out(int k);
    logic [4:0]  s;
    bit          fif, fie, red;
    logic [31:0] t;
    s = 5'b0; fif = 0; fie = 0; red = 0; t = 32'h0;
    if (!cur_rdy) begin
      s = 5'b11111;
    end else if (flush_left[k] > 0) begin
      if (cur_mem) begin s = 5'b01111; fif = 1; end
      else if (cur_br) begin red = 1; fif = 1; fie = 1; t = cur_tgt; end
      else fif = 1;
    end else begin
      if (cur_mem) s = 5'b01111;
      else if (cur_br) begin red = 1; fif = 1; fie = 1; t = cur_tgt; end
      else if (cur_lu) begin s = 5'b00011; fie = 1; end
      else if (cur_ifb) begin s = 5'b00001; fif = 1; end
    end
    exp_ctl[k]     = {s, fif, fie, red, t};
    exp_red[k]     = red;
    exp_lub[k]     = fie && !red;
    exp_stalled[k] = cur_rdy && (s != 5'b0);
  endfunction

  function automatic void model_update(int k);
    if (rst_in) begin
      flush_left[k] = 0;
      for (int j = 0; j < 3; j++) pcnt[k][j] = 0;
    end else if (cur_rdy) begin
      if (exp_stalled[k] && pcnt[k][0] < max_of(k)) pcnt[k][0]++;
      if (exp_red[k]     && pcnt[k][1] < max_of(k)) pcnt[k][1]++;
      if (exp_lub[k]     && pcnt[k][2] < max_of(k)) pcnt[k][2]++;
      if (exp_red[k]) flush_left[k] = fc_of(k) - 1;
      else if (flush_left[k] > 0 && !cur_mem) flush_left[k]--;
    end
  endfunction

  function automatic logic [95:0] exp_perf(int k);
    logic [31:0] c0, c1, c2;
    c0 = pcnt[k][0][31:0]; c1 = pcnt[k][1][31:0]; c2 = pcnt[k][2][31:0];
`ifdef PERF_CNT_EN
    return {c0, c1, c2};
`else
    return (c0 & 32'h0) | 96'h0;
`endif
  endfunction

  function automatic logic [39:0] obs_ctl(int k);
    if (k == 0) return {if_a.stall, if_a.flush_if_id, if_a.flush_id_ex, if_a.pc_redirect, if_a.pc_target};
    return {if_b.stall, if_b.flush_if_id, if_b.flush_id_ex, if_b.pc_redirect, if_b.pc_target};
  endfunction

  function automatic logic [95:0] obs_perf(int k);
    if (k == 0) return {if_a.perf_stall_cnt, if_a.perf_flush_cnt, if_a.perf_lu_cnt};
    return {28'h0, if_b.perf_stall_cnt, 28'h0, if_b.perf_flush_cnt, 28'h0, if_b.perf_lu_cnt};
  endfunction

  // Apply inputs just after a rising edge, then wait to the falling edge and form expectations.
  task automatic drive(input bit r, input bit rdy, input bit ifb, input bit mem,
                       input bit lu, input bit br, input logic [31:0] tgt);
    rst_in = r;
    cur_rdy = rdy; cur_ifb = ifb; cur_mem = mem; cur_lu = lu; cur_br = br; cur_tgt = tgt;
    if_a.rdy_in = rdy; if_a.if_busy = ifb; if_a.mem_busy = mem;
    if_a.id_load_use = lu; if_a.ex_branch_taken = br; if_a.ex_branch_target = tgt;
    if_b.rdy_in = rdy; if_b.if_busy = ifb; if_b.mem_busy = mem;
    if_b.id_load_use = lu; if_b.ex_branch_taken = br; if_b.ex_branch_target = tgt;
    @(negedge clk_in);
    for (int k = 0; k < 2; k++) model_out(k);
  endtask

  task automatic tick();
    @(posedge clk_in);
    for (int k = 0; k < 2; k++) model_update(k);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin drive(0, 1, 0, 0, 0, 0, 32'h0); tick(); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin drive(1, 1, 0, 0, 0, 0, 32'h0); tick(); end
    drive(0, 1, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_ctl(k) !== 40'h0) begin
        miscompares++;
        $display("FAIL reset_ctl[%0d]: got %h want %h", k, obs_ctl(k), 40'h0);
      end
      vectors++;
      if (obs_perf(k) !== 96'h0) begin
        miscompares++;
        $display("FAIL reset_perf[%0d]: got %h want 0", k, obs_perf(k));
      end
    end
    tick();
  endtask

  task automatic test_mem_then_branch();
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 0, (c < 3), 0, 1, 32'h0000_1040);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (c < 3 && (obs_ctl(k) !== {5'b01111, 3'b000, 32'h0})) begin
          miscompares++;
          $display("FAIL memwait_hold[%0d] cyc %0d: got %h want %h", k, c, obs_ctl(k), {5'b01111, 35'h0});
        end else if (c == 3 && (obs_ctl(k) !== {5'b00000, 3'b111, 32'h0000_1040})) begin
          miscompares++;
          $display("FAIL memwait_redirect[%0d]: got %h want %h", k, obs_ctl(k), {5'b0, 3'b111, 32'h1040});
        end
      end
      tick();
    end
    idle(4);
  endtask

  task automatic test_flush_len();
    int n_fif_a, n_fie_a, n_red_a, n_fif_b;
    n_fif_a = 0; n_fie_a = 0; n_red_a = 0; n_fif_b = 0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 0, 0, 0, (c == 0), 32'h0000_2000);
      n_fif_a += int'(if_a.flush_if_id);
      n_fie_a += int'(if_a.flush_id_ex);
      n_red_a += int'(if_a.pc_redirect);
      n_fif_b += int'(if_b.flush_if_id);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_ctl(k) !== exp_ctl[k]) begin
          miscompares++;
          $display("FAIL flush_seq[%0d] cyc %0d: got %h want %h", k, c, obs_ctl(k), exp_ctl[k]);
        end
      end
      tick();
    end
    vectors++;
    if (n_fif_a != 3 || n_fie_a != 1 || n_red_a != 1 || n_fif_b != 1) begin
      miscompares++;
      $display("FAIL flush_len: got fif=%0d fie=%0d red=%0d fif_b=%0d want 3 1 1 1",
               n_fif_a, n_fie_a, n_red_a, n_fif_b);
    end
  endtask

  task automatic test_lu_if();
    longint unsigned lu_before;
    lu_before = pcnt[0][2];
    drive(0, 1, 1, 0, 1, 0, 32'h0);
    vectors++;
    if (obs_ctl(0) !== {5'b00011, 3'b010, 32'h0}) begin
      miscompares++;
      $display("FAIL lu_if_ctl: got %h want %h", obs_ctl(0), {5'b00011, 3'b010, 32'h0});
    end
    tick();
    drive(0, 1, 0, 0, 0, 0, 32'h0);
    vectors++;
`ifdef PERF_CNT_EN
    if (if_a.perf_lu_cnt !== 32'(lu_before + 1)) begin
      miscompares++;
      $display("FAIL lu_perf: got %0d want %0d", if_a.perf_lu_cnt, lu_before + 1);
    end
`else
    if (if_a.perf_lu_cnt !== 32'h0) begin
      miscompares++;
      $display("FAIL lu_perf: got %0d want 0 (lu_before %0d)", if_a.perf_lu_cnt, lu_before);
    end
`endif
    tick();
  endtask

  task automatic test_rdy_freeze();
    // cycle 0 redirect, 1-2 frozen, 3-4 flush resumes, 5 clear (FLUSH_CYCLES=3 instance)
    bit want_fif [6] = '{1, 0, 0, 1, 1, 0};
    for (int c = 0; c < 6; c++) begin
      drive(0, !(c == 1 || c == 2), 0, 0, 0, (c == 0), 32'h0000_3000);
      vectors++;
      if (if_a.flush_if_id !== want_fif[c] ||
          ((c == 1 || c == 2) && if_a.stall !== 5'b11111)) begin
        miscompares++;
        $display("FAIL rdy_freeze cyc %0d: got stall=%b fif=%b want fif=%b", c, if_a.stall,
                 if_a.flush_if_id, want_fif[c]);
      end
      vectors++;
      if (obs_ctl(1) !== exp_ctl[1]) begin
        miscompares++;
        $display("FAIL rdy_freeze_b cyc %0d: got %h want %h", c, obs_ctl(1), exp_ctl[1]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 0, 0, 0, 1, 32'h0000_4000); tick();
    drive(1, 1, 0, 0, 0, 0, 32'h0); tick();
    drive(0, 1, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_ctl(k) !== 40'h0 || obs_perf(k) !== 96'h0) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: got ctl=%h perf=%h want 0", k, obs_ctl(k), obs_perf(k));
      end
    end
    tick();
  endtask

  task automatic test_perf_sat();
    drive(1, 1, 0, 0, 0, 0, 32'h0); tick();
    for (int i = 0; i < 20; i++) begin drive(0, 1, 0, 1, 0, 0, 32'h0); tick(); end
    drive(0, 1, 0, 0, 0, 0, 32'h0);
    vectors++;
`ifdef PERF_CNT_EN
    if (if_b.perf_stall_cnt !== 4'hF || if_a.perf_stall_cnt !== 32'd20) begin
      miscompares++;
      $display("FAIL perf_sat: got b=%h a=%0d want b=f a=20", if_b.perf_stall_cnt, if_a.perf_stall_cnt);
    end
`else
    if (if_b.perf_stall_cnt !== 4'h0 || if_a.perf_stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL perf_sat: got b=%h a=%0d want 0 0", if_b.perf_stall_cnt, if_a.perf_stall_cnt);
    end
`endif
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs_perf(k) !== exp_perf(k)) begin
        miscompares++;
        $display("FAIL perf_model[%0d]: got %h want %h", k, obs_perf(k), exp_perf(k));
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) >= 15),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), $urandom);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_ctl(k) !== exp_ctl[k]) begin
          miscompares++;
          $display("FAIL rand_ctl[%0d] cyc %0d: got %h want %h", k, i, obs_ctl(k), exp_ctl[k]);
        end
        vectors++;
        if (obs_perf(k) !== exp_perf(k)) begin
          miscompares++;
          $display("FAIL rand_perf[%0d] cyc %0d: got %h want %h", k, i, obs_perf(k), exp_perf(k));
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      flush_left[k] = 0;
      for (int j = 0; j < 3; j++) pcnt[k][j] = 0;
    end
    rst_in = 1'b1;
    cur_rdy = 1; cur_ifb = 0; cur_mem = 0; cur_lu = 0; cur_br = 0; cur_tgt = 32'h0;
    if_a.rdy_in = 1; if_a.if_busy = 0; if_a.mem_busy = 0;
    if_a.id_load_use = 0; if_a.ex_branch_taken = 0; if_a.ex_branch_target = 32'h0;
    if_b.rdy_in = 1; if_b.if_busy = 0; if_b.mem_busy = 0;
    if_b.id_load_use = 0; if_b.ex_branch_taken = 0; if_b.ex_branch_target = 32'h0;
    @(posedge clk_in);
    #1;

    test_reset();
    test_mem_then_branch();
    test_flush_len();
    test_lu_if();
    test_rdy_freeze();
    test_reset_mid();
    test_perf_sat();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
